// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic [0:0] state_t;

   localparam state_t IDLE = 1'b0;
   localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Purpose: one-bit full adder cell that also exposes propagate and generate.
// Latency: purely combinational.
// Backpressure: none, the cell has no handshake.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out,
   output logic p,
   output logic g
);

   assign p     = a ^ b;
   assign g     = a & b;
   assign s     = p ^ c_in;
   assign c_out = g | (p & c_in);

endmodule

// File: rtl/serial_adder.sv
// Purpose: LSB-first bit-serial adder, one bit per clock; SERIAL_ADDER_OVF_EN adds the ovf output.
// Latency: start accepted at edge k gives a one-cycle done pulse after edge k+WIDTH.
// Backpressure: start is ignored while busy; start is accepted again in the done cycle.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             all_p
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry;
   logic             p_acc;

   logic             fa_s;
   logic             fa_c;
   logic             fa_p;
   logic             fa_g_unused;

   logic [WIDTH-1:0] res_next;

   full_adder u_fa (
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .c_in  (carry),
      .s     (fa_s),
      .c_out (fa_c),
      .p     (fa_p),
      .g     (fa_g_unused)
   );

   // The freshly computed bit enters at the MSB, so after WIDTH shifts the LSB sits at bit 0.
   assign res_next = {fa_s, res_sh[WIDTH-1:1]};
   assign busy     = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         p_acc  <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         c_out  <= 1'b0;
         all_p  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= c_in;
                  cnt   <= '0;
                  p_acc <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               res_sh <= res_next;
               carry  <= fa_c;
               p_acc  <= p_acc & fa_p;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  sum   <= res_next;
                  c_out <= fa_c;
                  all_p <= p_acc & fa_p;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry still holds the carry into the MSB cell at this edge
                  ovf   <= carry ^ fa_c;
`endif
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: arithmetic reference model checked every cycle plus directed literal cases.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;
   logic         all_p;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int errors = 0;
   int checks = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out),
      .all_p (all_p)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an operation is a countdown of W edges, and the result is plain arithmetic.
   int           rem    = 0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_sum  = '0;
   logic         m_cout = 1'b0;
   logic         m_allp = 1'b0;
   logic         m_ovf  = 1'b0;
   logic [W-1:0] p_sum;
   logic         p_cout;
   logic         p_allp;
   logic         p_ovf;
   logic [W:0]   full;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem    = 0;
         m_done = 1'b0;
         m_sum  = '0;
         m_cout = 1'b0;
         m_allp = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         m_done = 1'b0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               m_done = 1'b1;
               m_sum  = p_sum;
               m_cout = p_cout;
               m_allp = p_allp;
               m_ovf  = p_ovf;
            end
         end else if (start === 1'b1) begin
            full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
            p_sum  = full[W-1:0];
            p_cout = full[W];
            p_allp = ((a ^ b) == {W{1'b1}});
            p_ovf  = (a[W-1] == b[W-1]) && (p_sum[W-1] != a[W-1]);
            rem    = W;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy",  {31'b0, busy},  {31'b0, (rem > 0)});
      chk("done",  {31'b0, done},  {31'b0, m_done});
      chk("sum",   {24'b0, sum},   {24'b0, m_sum});
      chk("c_out", {31'b0, c_out}, {31'b0, m_cout});
      chk("all_p", {31'b0, all_p}, {31'b0, m_allp});
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf",   {31'b0, ovf},   {31'b0, m_ovf});
`endif
   end

   // One operation; a nonzero glitch pulses start with other operands so that edge k+glitch samples it.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                        input int glitch, output int lat);
      @(negedge clk);
      a = ta; b = tb_v; c_in = tci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (lat == glitch - 1) begin
            start = 1'b1; a = ~ta; b = 8'h5A; c_in = ~tci;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
   endtask

   task automatic lit(input string name, input logic [W-1:0] es, input logic ec,
                      input logic ep, input logic eo);
      chk({name, "_sum"},   {24'b0, sum},   {24'b0, es});
      chk({name, "_c_out"}, {31'b0, c_out}, {31'b0, ec});
      chk({name, "_all_p"}, {31'b0, all_p}, {31'b0, ep});
`ifdef SERIAL_ADDER_OVF_EN
      chk({name, "_ovf"},   {31'b0, ovf},   {31'b0, eo});
`else
      if (eo === 1'bx) $display("unexpected x in ovf expectation for %s", name);
`endif
   endtask

   int lat;
   int n;

   initial begin
      rst_n = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      lit("rst", 8'h00, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;

      do_op(8'h0F, 8'h01, 1'b0, 0, lat);
      chk("lat_0f", lat, 8);
      lit("op_0f_01", 8'h10, 1'b0, 1'b0, 1'b0);

      do_op(8'hFF, 8'h01, 1'b0, 0, lat);
      lit("op_ff_01", 8'h00, 1'b1, 1'b0, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0, 0, lat);
      lit("op_7f_01", 8'h80, 1'b0, 1'b0, 1'b1);

      do_op(8'hAA, 8'h55, 1'b1, 0, lat);
      lit("op_aa_55", 8'h00, 1'b1, 1'b1, 1'b0);

      // start pulsed mid-operation must not disturb result or timing
      do_op(8'h3C, 8'h0F, 1'b0, 3, lat);
      chk("lat_glitch", lat, 8);
      lit("op_glitch", 8'h4B, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("glitch_idle", {31'b0, busy}, 32'd0);

      // start held high: second operation accepted in the done cycle
      a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      n = 0;
      while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("lat_b2b_1", n, 8);
      lit("op_b2b_1", 8'h00, 1'b1, 1'b0, 1'b1);
      a = 8'h12; b = 8'h34; c_in = 1'b1;
      @(negedge clk);
      chk("b2b_busy", {31'b0, busy}, 32'd1);
      n = 1;
      while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      start = 1'b0;
      // eight busy cycles separate the two done pulses
      chk("gap_b2b", n, 9);
      lit("op_b2b_2", 8'h47, 1'b0, 1'b0, 1'b0);

      // reset in the middle of an operation
      @(negedge clk);
      a = 8'h21; b = 8'h13; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_done", {31'b0, done}, 32'd0);
      end
      chk("abort_busy", {31'b0, busy}, 32'd0);
      lit("abort", 8'h00, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      do_op(8'h21, 8'h13, 1'b0, 0, lat);
      chk("lat_after_rst", lat, 8);
      lit("op_after_rst", 8'h34, 1'b0, 1'b0, 1'b0);

      // random traffic, including operand pairs that propagate on every bit and rare resets
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         a     = W'($urandom);
         b     = ($urandom_range(0, 3) == 0) ? ~a : W'($urandom);
         c_in  = 1'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end
      start = 1'b0;
      repeat (12) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
